seq_concat_lhs_pack: RTL and testbench
======================================

// Module: seq_concat_lhs_pack
// PURPOSE
//  Parametrised packed register pair {q, r} with load/rotate/add modes, a carry
//  flag and a configurable output delay pipeline with a valid strobe.
//  Front-end/extractor benchmark: every stage-0 update writes its destinations
//  through a concatenation LHS ({carry, q, r} <= ...) spanning separate nets.
//  The netlist extractor must resolve each of these bit-by-bit onto per-net DFFs.
//  Successor to the single-mode 4+4-bit concat-LHS clear register.
// PARAMETERS
//  QW     4  width of upper field q (>=1)
//  RW     4  width of lower field r (>=1)
//  DEPTH  2  pipeline stages from operating register to outputs (>=1)
// PORTS
//  clk    in   1      clock, all state updates on posedge
//  rst_n  in   1      synchronous active-low reset
//  en     in   1      operation enable; 0 = hold
//  mode   in   2      00 HOLD, 01 LOAD, 10 ROTATE, 11 ADD
//  din    in   QW+RW  operand for LOAD/ADD; din[QW+RW-1:RW] maps to q
//  q      out  QW     upper field, last pipeline stage
//  r      out  RW     lower field, last pipeline stage
//  carry  out  1      carry/shift-out flag, last pipeline stage
//  valid  out  1      high when outputs reflect an op issued with en=1
// BEHAVIOUR
//  - W = QW+RW. Stage 0 holds {c0, q0, r0}. Stages 1..DEPTH-1 are plain delays.
//    Outputs come from stage DEPTH-1.
//  - Reset: rst_n sampled at posedge. It has priority over en.
//    All stages, q, r, carry and valid clear to 0 on the same edge.
//  - Stage 0 update, applied only when en=1 and rst_n=1:
//    HOLD   : {c0,q0,r0} unchanged.
//    LOAD   : {c0,q0,r0} <= {1'b0, din}.
//    ROTATE : {q0,r0} <= {q0,r0} rotated left by 1 across the field boundary.
//             MSB of q0 moves to LSB of r0 side bit 0; c0 <= old MSB.
//    ADD    : {c0,q0,r0} <= {1'b0,q0,r0} + {1'b0,din}, a (W+1)-bit sum.
//             Wrap-around is mod 2^W; overflow lands in c0.
//  - en=0: stage 0 holds regardless of mode/din. A 0 enters the valid pipe.
//  - Valid pipe: v0 <= en each edge (0 under reset).
//    valid = en delayed DEPTH edges, aligned with the data of the same op.
//  - Latency: op sampled at edge k appears on q/r/carry after edge k+DEPTH-1.
//    DEPTH=1 means visible right after the capturing edge.
//  - Back-to-back ops: one per cycle, no stall. Each op uses stage-0 state
//    as updated by the previous edge.
//  - Reset mid-operation flushes in-flight pipeline data; no partial results.
//  - Delay stages always shift (no enable); only stage 0 honours en.
// TESTING (QW=4, RW=4, DEPTH=2 unless noted)
//  1. rst_n=0 for 2 edges, en=1 mode=LOAD din=8'hFF
//     -> q=0, r=0, carry=0, valid=0 (reset beats en).
//  2. Release; LOAD din=8'hA5 at edge k
//     -> after edge k+1: q=4'hA, r=4'h5, carry=0, valid=1 for one cycle.
//  3. From A5, ROTATE -> {q,r}=8'h4B, carry=1; second ROTATE -> 8'h96, carry=0.
//  4. From 4B, ADD din=8'hC0 -> sum 9'h10B: carry=1, q=4'h0, r=4'hB.
//     ADD din=8'h00 -> carry=0, value kept.
//  5. en=0, mode=LOAD, din=8'hFF for 3 cycles -> q/r/carry frozen, valid=0.
//     Mode HOLD with en=1 -> unchanged, valid=1.
//  6. Issue LOAD 8'h3C then pull rst_n low on the next edge
//     -> all outputs 0 next edge, 3C never appears.
//     Repeat tests 2-4 with QW=3, RW=5, DEPTH=1, latency 1.

Source files
------------

// File: rtl/seq_concat_lhs_pack.sv
// rtl/seq_concat_lhs_pack.sv - packed {carry,q,r} register with load/rotate/add modes and delay pipeline
module seq_concat_lhs_pack #(
    parameter int QW    = 4,
    parameter int RW    = 4,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [QW+RW-1:0]  din,
    output logic [QW-1:0]     q,
    output logic [RW-1:0]     r,
    output logic              carry,
    output logic              valid
);
    localparam int W = QW + RW;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_LOAD   = 2'b01,
        MODE_ROTATE = 2'b10,
        MODE_ADD    = 2'b11
    } mode_t;

    mode_t         w_mode;
    logic          r_v0;
    logic          r_c0;
    logic [QW-1:0] r_q0;
    logic [RW-1:0] r_r0;
    logic [W-1:0]  w_qr;
    logic [W:0]    w_sum;
    logic [W+1:0]  w_s0;
    logic [W+1:0]  w_out;

    assign w_mode = mode_t'(mode);
    assign w_qr   = {r_q0, r_r0};
    assign w_sum  = {1'b0, w_qr} + {1'b0, din};
    assign w_s0   = {r_v0, r_c0, r_q0, r_r0};

    // Every stage-0 write lands on the three separate nets through one concatenation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {r_c0, r_q0, r_r0} <= '0;
        end else if (en) begin
            case (w_mode)
                MODE_HOLD:   {r_c0, r_q0, r_r0} <= {r_c0, r_q0, r_r0};
                MODE_LOAD:   {r_c0, r_q0, r_r0} <= {1'b0, din};
                MODE_ROTATE: {r_c0, r_q0, r_r0} <= {w_qr[W-1], w_qr[W-2:0], w_qr[W-1]};
                MODE_ADD:    {r_c0, r_q0, r_r0} <= w_sum;
                default:     {r_c0, r_q0, r_r0} <= {r_c0, r_q0, r_r0};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v0 <= 1'b0;
        end else begin
            r_v0 <= en;
        end
    end

    // Valid travels with its data word so both see identical delay.
    generate
        if (DEPTH == 1) begin : g_direct
            assign w_out = w_s0;
        end else begin : g_pipe
            logic [W+1:0] r_dly [DEPTH-1];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        r_dly[i] <= '0;
                    end
                end else begin
                    r_dly[0] <= w_s0;
                    for (int i = 1; i < DEPTH - 1; i++) begin
                        r_dly[i] <= r_dly[i-1];
                    end
                end
            end

            assign w_out = r_dly[DEPTH-2];
        end
    endgenerate

    assign {valid, carry, q, r} = w_out;

endmodule

// File: tb/tb_seq_concat_lhs_pack.sv
// tb/tb_seq_concat_lhs_pack.sv - scoreboard bench for two configurations of seq_concat_lhs_pack
module tb_seq_concat_lhs_pack;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [7:0] din;

    logic [3:0] qa;
    logic [3:0] ra;
    logic       ca;
    logic       va;
    logic [2:0] qb;
    logic [4:0] rb;
    logic       cb;
    logic       vb;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] m_st;
    logic [9:0] sb_a[$];
    logic [9:0] sb_b[$];

    always #5 clk = ~clk;

    seq_concat_lhs_pack #(.QW(4), .RW(4), .DEPTH(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .din(din),
        .q(qa), .r(ra), .carry(ca), .valid(va)
    );

    seq_concat_lhs_pack #(.QW(3), .RW(5), .DEPTH(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .din(din),
        .q(qb), .r(rb), .carry(cb), .valid(vb)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive, update the reference, then compare each DUT against its queue head.
    task automatic step(input logic rs, input logic e, input logic [1:0] m, input logic [7:0] d);
        logic [9:0] ent;
        logic [9:0] ea;
        logic [9:0] eb;
        @(negedge clk);
        rst_n = rs;
        en    = e;
        mode  = m;
        din   = d;
        @(posedge clk);
        if (!rs) begin
            m_st = '0;
            ent  = '0;
            sb_a.delete();
            sb_b.delete();
            sb_a.push_back('0);
        end else begin
            if (e) begin
                case (m)
                    2'b01:   m_st = {1'b0, d};
                    2'b10:   m_st = {m_st[7], m_st[6:0], m_st[7]};
                    2'b11:   m_st = {1'b0, m_st[7:0]} + {1'b0, d};
                    default: m_st = m_st;
                endcase
            end
            ent = {e, m_st};
        end
        sb_a.push_back(ent);
        sb_b.push_back(ent);
        #1;
        if (sb_a.size() != 2 || sb_b.size() != 1) begin
            check_eq("sb_depth", 32'(sb_a.size()), 32'd2);
        end else begin
            ea = sb_a.pop_front();
            eb = sb_b.pop_front();
            check_eq("a_q",     32'(qa), 32'(ea[7:4]));
            check_eq("a_r",     32'(ra), 32'(ea[3:0]));
            check_eq("a_carry", 32'(ca), 32'(ea[8]));
            check_eq("a_valid", 32'(va), 32'(ea[9]));
            check_eq("b_q",     32'(qb), 32'(eb[7:5]));
            check_eq("b_r",     32'(rb), 32'(eb[4:0]));
            check_eq("b_carry", 32'(cb), 32'(eb[8]));
            check_eq("b_valid", 32'(vb), 32'(eb[9]));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 2'b00;
        din   = 8'h00;
        m_st  = '0;

        step(1'b0, 1'b1, 2'b01, 8'hFF);
        step(1'b0, 1'b1, 2'b01, 8'hFF);
        check_eq("rst_a_out", 32'({va, ca, qa, ra}), 32'h0);
        check_eq("rst_b_out", 32'({vb, cb, qb, rb}), 32'h0);

        step(1'b1, 1'b1, 2'b01, 8'hA5);
        check_eq("b_load_a5", 32'({cb, qb, rb}), 32'h0A5);
        step(1'b1, 1'b1, 2'b10, 8'h00);
        check_eq("a_load_a5", 32'({va, ca, qa, ra}), 32'h2A5);
        step(1'b1, 1'b1, 2'b10, 8'h00);
        check_eq("a_rot_4b", 32'({ca, qa, ra}), 32'h14B);
        step(1'b1, 1'b1, 2'b01, 8'h4B);
        check_eq("a_rot_96", 32'({ca, qa, ra}), 32'h096);
        step(1'b1, 1'b1, 2'b11, 8'hC0);
        step(1'b1, 1'b1, 2'b11, 8'h00);
        check_eq("a_add_10b", 32'({ca, qa, ra}), 32'h10B);
        step(1'b1, 1'b0, 2'b01, 8'hFF);
        check_eq("a_add_00", 32'({va, ca, qa, ra}), 32'h20B);
        step(1'b1, 1'b0, 2'b01, 8'hFF);
        check_eq("a_en0_frozen", 32'({va, ca, qa, ra}), 32'h00B);
        step(1'b1, 1'b0, 2'b01, 8'hFF);
        step(1'b1, 1'b1, 2'b00, 8'hFF);
        step(1'b1, 1'b1, 2'b01, 8'h3C);
        check_eq("a_hold", 32'({va, ca, qa, ra}), 32'h20B);
        step(1'b0, 1'b1, 2'b00, 8'h00);
        check_eq("a_flush", 32'({va, ca, qa, ra}), 32'h0);
        step(1'b1, 1'b0, 2'b00, 8'h00);
        check_eq("a_no_3c", 32'({va, ca, qa, ra}), 32'h0);

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 24) != 0), ($urandom_range(0, 4) != 0),
                 2'($urandom_range(0, 3)), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
